// File: rtl/cmult_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cmult_stream
//  Brief    : Streaming complex multiplier p = a*b or a*conj(b) with valid/ready
//             backpressure, round-half-up rescale, overflow flag and a sideband
//             tag. Define CMULT_STREAM_SAT_EN to saturate overflowed components.
//  Revision : 1.0  initial release
// ============================================================================
module cmult_stream #(
    parameter int AWIDTH  = 16,
    parameter int BWIDTH  = 16,
    parameter int PWIDTH  = 16,
    parameter int SRABITS = 15,
    parameter int TWIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [AWIDTH-1:0] s_ar,
    input  logic signed [AWIDTH-1:0] s_ai,
    input  logic signed [BWIDTH-1:0] s_br,
    input  logic signed [BWIDTH-1:0] s_bi,
    input  logic                     s_conj,
    input  logic [TWIDTH-1:0]        s_tag,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [PWIDTH-1:0]        m_pr,
    output logic [PWIDTH-1:0]        m_pi,
    output logic [TWIDTH-1:0]        m_tag,
    output logic                     m_ovf,
    input  logic                     ovf_clr,
    output logic                     ovf_sticky
);
    localparam int FW  = AWIDTH + BWIDTH + 2;
    localparam int RW  = FW - SRABITS;
    localparam int AW1 = AWIDTH + 1;
    localparam int BW1 = BWIDTH + 1;
    localparam int BW2 = BWIDTH + 2;
    localparam logic signed [FW-1:0] c_rnd = FW'(1) << (SRABITS - 1);

    logic w_ce;
    assign w_ce    = m_ready || !m_valid;
    assign s_ready = w_ce;

    // Valid and tag for stages 1..5 travel as shift registers.
    logic [4:0]             r_vld;
    logic [4:0][TWIDTH-1:0] r_tag;

    logic signed [AWIDTH-1:0] r_s1_ar, r_s1_ai;
    logic signed [BWIDTH-1:0] r_s1_br, r_s1_bi;
    logic                     r_s1_conj;

    logic signed [AWIDTH-1:0] r_s2_ar, r_s2_ai;
    logic signed [BWIDTH-1:0] r_s2_br;
    logic signed [AW1-1:0]    r_s2_sa;
    logic signed [BW2-1:0]    r_s2_dbr, r_s2_sbr;

    logic signed [FW-1:0]     r_s3_k1, r_s3_k2, r_s3_k3;
    logic signed [FW-1:0]     r_s4_pr, r_s4_pi;

    logic signed [PWIDTH-1:0] r_s5_pr, r_s5_pi;
    logic                     r_s5_ovf;

    // bi' carries one extra bit so negating the most negative value is exact.
    logic signed [BW1-1:0]    w_bi_c;
    logic signed [AW1-1:0]    w_sa;
    logic signed [BW2-1:0]    w_dbr, w_sbr;

    assign w_bi_c = r_s1_conj ? -BW1'(r_s1_bi) : BW1'(r_s1_bi);
    assign w_sa   = AW1'(r_s1_ar) + AW1'(r_s1_ai);
    assign w_dbr  = BW2'(w_bi_c) - BW2'(r_s1_br);
    assign w_sbr  = BW2'(r_s1_br) + BW2'(w_bi_c);

    logic signed [RW-1:0]     w_rr_pr, w_rr_pi;
    logic signed [PWIDTH-1:0] w_q_pr, w_q_pi;
    logic                     w_ovf;

    assign w_rr_pr = RW'(r_s4_pr >>> SRABITS);
    assign w_rr_pi = RW'(r_s4_pi >>> SRABITS);

    generate
        if (PWIDTH < RW) begin : g_narrow
            logic [RW-PWIDTH:0] w_top_r, w_top_i;
            logic               w_ovf_r, w_ovf_i;
            assign w_top_r = w_rr_pr[RW-1:PWIDTH-1];
            assign w_top_i = w_rr_pi[RW-1:PWIDTH-1];
            // In range only if every bit above the result sign matches it.
            assign w_ovf_r = !((&w_top_r) || !(|w_top_r));
            assign w_ovf_i = !((&w_top_i) || !(|w_top_i));
            assign w_ovf   = w_ovf_r || w_ovf_i;
`ifdef CMULT_STREAM_SAT_EN
            localparam logic [PWIDTH-1:0] c_pmax = {1'b0, {(PWIDTH-1){1'b1}}};
            localparam logic [PWIDTH-1:0] c_pmin = {1'b1, {(PWIDTH-1){1'b0}}};
            assign w_q_pr = w_ovf_r ? (w_rr_pr[RW-1] ? c_pmin : c_pmax) : w_rr_pr[PWIDTH-1:0];
            assign w_q_pi = w_ovf_i ? (w_rr_pi[RW-1] ? c_pmin : c_pmax) : w_rr_pi[PWIDTH-1:0];
`else
            assign w_q_pr = w_rr_pr[PWIDTH-1:0];
            assign w_q_pi = w_rr_pi[PWIDTH-1:0];
`endif
        end else begin : g_wide
            assign w_q_pr = PWIDTH'(w_rr_pr);
            assign w_q_pi = PWIDTH'(w_rr_pi);
            assign w_ovf  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= '0;
            r_tag     <= '0;
            r_s1_ar   <= '0;
            r_s1_ai   <= '0;
            r_s1_br   <= '0;
            r_s1_bi   <= '0;
            r_s1_conj <= 1'b0;
            r_s2_ar   <= '0;
            r_s2_ai   <= '0;
            r_s2_br   <= '0;
            r_s2_sa   <= '0;
            r_s2_dbr  <= '0;
            r_s2_sbr  <= '0;
            r_s3_k1   <= '0;
            r_s3_k2   <= '0;
            r_s3_k3   <= '0;
            r_s4_pr   <= '0;
            r_s4_pi   <= '0;
            r_s5_pr   <= '0;
            r_s5_pi   <= '0;
            r_s5_ovf  <= 1'b0;
            m_valid   <= 1'b0;
            m_pr      <= '0;
            m_pi      <= '0;
            m_tag     <= '0;
            m_ovf     <= 1'b0;
        end else if (w_ce) begin
            r_vld     <= {r_vld[3:0], s_valid};
            r_tag     <= {r_tag[3:0], s_tag};
            r_s1_ar   <= s_ar;
            r_s1_ai   <= s_ai;
            r_s1_br   <= s_br;
            r_s1_bi   <= s_bi;
            r_s1_conj <= s_conj;
            r_s2_ar   <= r_s1_ar;
            r_s2_ai   <= r_s1_ai;
            r_s2_br   <= r_s1_br;
            r_s2_sa   <= w_sa;
            r_s2_dbr  <= w_dbr;
            r_s2_sbr  <= w_sbr;
            // Three-multiplier form: pr = k1 - k3, pi = k1 + k2.
            r_s3_k1   <= FW'(r_s2_br) * FW'(r_s2_sa);
            r_s3_k2   <= FW'(r_s2_ar) * FW'(r_s2_dbr);
            r_s3_k3   <= FW'(r_s2_ai) * FW'(r_s2_sbr);
            r_s4_pr   <= r_s3_k1 - r_s3_k3 + c_rnd;
            r_s4_pi   <= r_s3_k1 + r_s3_k2 + c_rnd;
            r_s5_pr   <= w_q_pr;
            r_s5_pi   <= w_q_pi;
            r_s5_ovf  <= w_ovf;
            m_valid   <= r_vld[4];
            m_pr      <= r_s5_pr;
            m_pi      <= r_s5_pi;
            m_tag     <= r_tag[4];
            m_ovf     <= r_s5_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (m_valid && m_ready && m_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cmult_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cmult_stream
//  Brief    : Scoreboard bench for cmult_stream at default parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmult_stream;
    localparam longint PMAX = 32767;
    localparam longint PMIN = -32768;
    localparam int     SRA  = 15;
`ifdef CMULT_STREAM_SAT_EN
    localparam int OVF_PR = 32767;
`else
    localparam int OVF_PR = -32768;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_ar = '0, s_ai = '0, s_br = '0, s_bi = '0;
    logic               s_conj = 1'b0;
    logic [3:0]         s_tag = '0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic signed [15:0] m_pr, m_pi;
    logic [3:0]         m_tag;
    logic               m_ovf;
    logic               ovf_clr = 1'b0;
    logic               ovf_sticky;

    cmult_stream dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_ar(s_ar), .s_ai(s_ai), .s_br(s_br), .s_bi(s_bi),
        .s_conj(s_conj), .s_tag(s_tag),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_pr(m_pr), .m_pi(m_pi), .m_tag(m_tag), .m_ovf(m_ovf),
        .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] pr;
        logic signed [15:0] pi;
        logic [3:0]         tag;
        logic               ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic signed [15:0] fit(input longint v);
`ifdef CMULT_STREAM_SAT_EN
        if (v > PMAX) return 16'sh7fff;
        if (v < PMIN) return 16'sh8000;
`endif
        return v[15:0];
    endfunction

    // Reference: exact complex product, then floor((x + 2^(S-1)) / 2^S).
    function automatic exp_t model(input logic signed [15:0] ar, ai, br, bi,
                                   input logic conj, input logic [3:0] tag);
        longint a_r, a_i, b_r, b_i, fr, fi, rr, ri;
        exp_t   e;
        a_r = ar; a_i = ai; b_r = br; b_i = bi;
        if (conj) begin
            fr = a_r * b_r + a_i * b_i;
            fi = a_i * b_r - a_r * b_i;
        end else begin
            fr = a_r * b_r - a_i * b_i;
            fi = a_i * b_r + a_r * b_i;
        end
        rr = (fr + (64'sd1 <<< (SRA - 1))) >>> SRA;
        ri = (fi + (64'sd1 <<< (SRA - 1))) >>> SRA;
        e.ovf = (rr > PMAX) || (rr < PMIN) || (ri > PMAX) || (ri < PMIN);
        e.pr  = fit(rr);
        e.pi  = fit(ri);
        e.tag = tag;
        return e;
    endfunction

    function automatic exp_t mk(input int pr, input int pi, input int tag, input bit ovf);
        exp_t e;
        e.pr = 16'(pr); e.pi = 16'(pi); e.tag = 4'(tag); e.ovf = ovf;
        return e;
    endfunction

    function automatic logic signed [15:0] rnd16();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 16'sh8000;
        if (sel == 1) return 16'sh7fff;
        return 16'($urandom);
    endfunction

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Output monitor: pops the scoreboard on every output transfer and
    // verifies that a stalled output does not change.
    logic               hold_v = 1'b0;
    logic signed [15:0] hold_pr, hold_pi;
    logic [3:0]         hold_tag;
    logic               hold_ovf;
    exp_t               got;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && m_valid) begin
                checks++;
                if (m_pr !== hold_pr || m_pi !== hold_pi || m_tag !== hold_tag || m_ovf !== hold_ovf) begin
                    errors++;
                    $display("FAIL stall_stable: got pr=%0d pi=%0d tag=%0d ovf=%0d expected pr=%0d pi=%0d tag=%0d ovf=%0d",
                             m_pr, m_pi, m_tag, m_ovf, hold_pr, hold_pi, hold_tag, hold_ovf);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got pr=%0d pi=%0d tag=%0d expected no output", m_pr, m_pi, m_tag);
                end else begin
                    got = sb.pop_front();
                    if (m_pr !== got.pr || m_pi !== got.pi || m_tag !== got.tag || m_ovf !== got.ovf) begin
                        errors++;
                        $display("FAIL output: got pr=%0d pi=%0d tag=%0d ovf=%0d expected pr=%0d pi=%0d tag=%0d ovf=%0d",
                                 m_pr, m_pi, m_tag, m_ovf, got.pr, got.pi, got.tag, got.ovf);
                    end
                end
            end
            hold_v   = m_valid && !m_ready;
            hold_pr  = m_pr;
            hold_pi  = m_pi;
            hold_tag = m_tag;
            hold_ovf = m_ovf;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input bit conj, input int tag, input exp_t ex);
        s_ar = 16'(ar); s_ai = 16'(ai); s_br = 16'(br); s_bi = 16'(bi);
        s_conj = conj; s_tag = 4'(tag);
        s_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_ready) begin
                sb.push_back(ex);
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("send_timeout", 1'b0, 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain", sb.size() == 0, sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int sent;
        exp_t e;

        // Reset state
        #12;
        chk("rst_m_valid", m_valid == 1'b0, m_valid, 0);
        chk("rst_outputs", {m_pr, m_pi, m_tag, m_ovf} == '0, {m_pr, m_pi, m_tag, m_ovf}, 0);
        chk("rst_sticky", ovf_sticky == 1'b0, ovf_sticky, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("s_ready_after_reset", s_ready == 1'b1, s_ready, 1);

        // Latency: accepting edge counts as edge 1
        s_ar = 16384; s_ai = 0; s_br = 16384; s_bi = 0; s_conj = 0; s_tag = 5;
        s_valid = 1'b1;
        @(negedge clk);
        sb.push_back(mk(8192, 0, 5, 0));
        @(posedge clk);
        n = 1;
        #1 s_valid = 1'b0;
        while (!m_valid && n < 20) begin
            @(posedge clk); n++; #1;
        end
        chk("latency", n == 6, n, 6);
        drain();

        // Directed arithmetic and rounding vectors, back to back
        send(16384, 16384, 0, 16384, 1, 1, mk(8192, -8192, 1, 0));
        send(16384, 16384, 0, 16384, 0, 2, mk(-8192, 8192, 2, 0));
        send(1, 0, 16384, 0, 0, 3, mk(1, 0, 3, 0));
        send(1, 0, 16383, 0, 0, 4, mk(0, 0, 4, 0));
        send(-1, 0, 16384, 0, 0, 6, mk(0, 0, 6, 0));
        drain();

        // Overflow and sticky status
        send(-32768, 0, -32768, 0, 0, 7, mk(OVF_PR, 0, 7, 1));
        drain();
        chk("sticky_set", ovf_sticky == 1'b1, ovf_sticky, 1);
        send(-32768, 0, -32768, 0, 0, 8, mk(OVF_PR, 0, 8, 1));
        for (n = 0; n < 20 && !m_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("ovf_output_wait", m_valid == 1'b1, m_valid, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("sticky_set_wins", ovf_sticky == 1'b1, ovf_sticky, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("sticky_clear", ovf_sticky == 1'b0, ovf_sticky, 0);
        drain();

        send(-32768, 0, -32768, 0, 1, 9, mk(OVF_PR, 0, 9, 1));
        drain();

        // Randomised traffic with random backpressure
        sent = 0;
        for (int cyc = 0; cyc < 20000 && sent < 200; cyc++) begin
            m_ready = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            s_ar = rnd16(); s_ai = rnd16(); s_br = rnd16(); s_bi = rnd16();
            s_conj = 1'($urandom_range(0, 1));
            s_tag = 4'($urandom);
            @(negedge clk);
            if (s_valid && s_ready) begin
                sb.push_back(model(s_ar, s_ai, s_br, s_bi, s_conj, s_tag));
                sent++;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("random_sent", sent == 200, sent, 200);
        drain();

        // Asynchronous reset with four samples in flight
        chk("sticky_pre_reset", ovf_sticky == 1'b1, ovf_sticky, 1);
        for (int i = 0; i < 4; i++) begin
            s_ar = -32768; s_ai = rnd16(); s_br = -32768; s_bi = rnd16();
            s_conj = 0; s_tag = 4'(10 + i);
            s_valid = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        for (n = 0; n < 20 && !m_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("inflight_visible", m_valid == 1'b1, m_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_valid", m_valid == 1'b0, m_valid, 0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("reset_sticky", ovf_sticky == 1'b0, ovf_sticky, 0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_ar = rnd16(); s_ai = rnd16(); s_br = rnd16(); s_bi = rnd16();
            e = model(s_ar, s_ai, s_br, s_bi, 1'b0, 4'(i + 1));
            send(s_ar, s_ai, s_br, s_bi, 0, i + 1, e);
        end
        drain();
        repeat (10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cmult_stream.md
Name: cmult_stream

Overview:
- Streaming, parametrised complex multiplier p = a·b, or p = a·conj(b) selectable per sample.
- Valid/ready handshake with full backpressure.
- Convergent-free round-half-up rescaling, per-sample overflow flag with optional saturation, sticky overflow status.
- Used between mixer/NCO and filter chains wherever samples must stall without loss; carries a sideband tag (channel/TDM index) aligned with each product.

Parameters:
- AWIDTH, 16, width of signed a operand components.
- BWIDTH, 16, width of signed b operand components.
- PWIDTH, 16, width of signed product components; 2 <= PWIDTH <= AWIDTH+BWIDTH+1.
- SRABITS, 15, arithmetic right shift applied to the full product; 1 <= SRABITS <= AWIDTH+BWIDTH.
- TWIDTH, 4, width of sideband tag; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept input this cycle.
- s_ar, s_ai  in  AWIDTH  a real/imag, two's complement.
- s_br, s_bi  in  BWIDTH  b real/imag, two's complement.
- s_conj  in  1  1: multiply by conj(b) for this sample.
- s_tag  in  TWIDTH  sideband, returned unchanged with the product.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts output.
- m_pr, m_pi  out  PWIDTH  product real/imag.
- m_tag  out  TWIDTH  tag of this product.
- m_ovf  out  1  this product overflowed PWIDTH.
- ovf_clr  in  1  synchronous clear of ovf_sticky.
- ovf_sticky  out  1  set when any overflowed product is transferred out.

Behaviour:
- Reset: all stage valids, m_valid, m_pr, m_pi, m_tag, m_ovf and ovf_sticky = 0. s_ready = 1 once rst deasserts. Reset mid-stream discards every in-flight sample.
- Transfer rules:
  - Input transfer occurs when s_valid && s_ready.
  - Output transfer occurs when m_valid && m_ready.
  - m_pr, m_pi, m_tag and m_ovf hold stable while m_valid && !m_ready.
- Pipeline: 6 stages with global enable ce = m_ready || !m_valid. s_ready = ce, which is combinational from m_ready by design.
  - When ce = 0, no stage register changes.
  - Bubbles (stage valid = 0) propagate and are squeezed out. Each stage register is written only while ce = 1.
- Latency: a sample accepted at edge k is presented with m_valid = 1 after edge k+6 if ce stays 1. Sustained throughput is 1 sample/clk.
- Stage order:
  1. Input register.
  2. Conjugate: bi' = s_conj ? -bi : bi, held at BWIDTH+1 so -(-2^(BWIDTH-1)) is exact. Pre-adds use the same 3-multiplier factorisation as the existing multiplier.
  3. Multiplies.
  4. Post-add plus rounding constant 2^(SRABITS-1).
  5. Shift and overflow/saturation.
  6. Output register.
- Arithmetic:
  - Full product width FW = AWIDTH+BWIDTH+2, exact, no internal overflow.
  - Normal mode: pr = ar·br − ai·bi, pi = ai·br + ar·bi.
  - Conjugate mode: pr = ar·br + ai·bi, pi = ai·br − ar·bi.
  - Result = floor((full + 2^(SRABITS-1)) / 2^SRABITS), i.e. round half toward +inf.
- Overflow: m_ovf = 1 if the rounded result of either component is outside [−2^(PWIDTH−1), 2^(PWIDTH−1)−1]. m_ovf is a constant 0 if that range can never be exceeded.
- ovf_sticky:
  - Set on output transfer with m_ovf = 1.
  - Cleared by ovf_clr.
  - If set and clear coincide, set wins.
- m_tag is delayed in lockstep with its sample; the tag is never reordered.

Optional Feature:
- Macro CMULT_STREAM_SAT_EN.
- Defined: an overflowed component clamps to 2^(PWIDTH−1)−1 (positive) or −2^(PWIDTH−1) (negative); the other component is unaffected.
- Undefined: an overflowed component wraps (low PWIDTH bits of the rounded result).
- m_ovf and ovf_sticky behave identically in both builds.

Test Plan:
- Defaults, m_ready = 1. a = (16384, 0), b = (16384, 0), conj = 0, tag = 5 -> m_pr = 8192, m_pi = 0, m_tag = 5, m_ovf = 0; m_valid rises exactly 6 edges after acceptance.
- a = (16384, 16384), b = (0, 16384), conj = 1 -> m_pr = 8192, m_pi = −8192. Same input with conj = 0 -> m_pr = −8192, m_pi = 8192.
- Rounding:
  - a = (1, 0), b = (16384, 0) -> m_pr = 1.
  - a = (1, 0), b = (16383, 0) -> m_pr = 0.
  - a = (−1, 0), b = (16384, 0) -> m_pr = 0.
- a = (−32768, 0), b = (−32768, 0):
  - Every build: m_ovf = 1, ovf_sticky = 1 after the output transfer.
  - SAT build: m_pr = 32767.
  - Wrap build: m_pr = −32768.
  - ovf_clr asserted on the same cycle as a second overflow transfer -> ovf_sticky stays 1; next cycle with ovf_clr only -> 0.
- Backpressure: 200 random samples with random s_valid and m_ready (about 50% each) -> outputs match a reference model in order with tags intact, with no drop or duplication; outputs stay stable while stalled.
- Reset asserted asynchronously with 4 samples in flight -> m_valid = 0 immediately. After release, only post-reset samples emerge and ovf_sticky = 0.
